// File: rtl/grad_window.sv
`timescale 1ns/1ps
// grad_window: builds the 4-neighbour cross {top, bottom, left, right} around
// every interior pixel of a raster-order stream, using two line buffers and a
// few delay registers. Output is a single-entry register that passes through
// on accept.
module grad_window #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*PIX_W-1:0] out_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    // lb1 holds row y-1, lb2 holds row y-2, both indexed by column
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    logic [XW-1:0]    x_reg;
    logic [YW-1:0]    y_reg;
    logic [PIX_W-1:0] prev_in_reg;
    logic [PIX_W-1:0] r1_d1_reg;
    logic [PIX_W-1:0] r1_d2_reg;
    logic [PIX_W-1:0] r2_d1_reg;

    logic [PIX_W-1:0]   r1;
    logic [PIX_W-1:0]   r2;
    logic               xfer;
    logic               emit;
    logic               x_wrap;
    logic               frame_end;
    logic [PIX_W-1:0]   field [4];
    logic [4*PIX_W-1:0] window_next;

    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign x_wrap    = (x_reg == X_LAST);
    assign frame_end = x_wrap && (y_reg == Y_LAST);
    // Only interior centres produce a window: need two rows and two columns seen
    assign emit      = xfer && (y_reg >= YW'(2)) && (x_reg >= XW'(2));

    // Line buffers are read before the write of the same transfer
    assign r1 = lb1[x_reg];
    assign r2 = lb2[x_reg];

    // Cross fields in output order, top first
    assign field[0] = r2_d1_reg;    // P(y-2, x-1)
    assign field[1] = prev_in_reg;  // P(y,   x-1)
    assign field[2] = r1_d2_reg;    // P(y-1, x-2)
    assign field[3] = r1;           // P(y-1, x)

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign window_next[(4-gi)*PIX_W-1 -: PIX_W] = field[gi];
        end
    endgenerate

    // Line buffer shift: new pixel into lb1, the displaced row-above pixel into lb2
    always_ff @(posedge clk) begin
        if (xfer) begin
            lb1[x_reg] <= in_pixel;
            lb2[x_reg] <= r1;
        end
    end

    // Raster counters and delay registers, advanced only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg       <= '0;
            y_reg       <= '0;
            prev_in_reg <= '0;
            r1_d1_reg   <= '0;
            r1_d2_reg   <= '0;
            r2_d1_reg   <= '0;
        end else if (xfer) begin
            x_reg       <= x_wrap ? '0 : x_reg + XW'(1);
            if (x_wrap) begin
                y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
            end
            prev_in_reg <= in_pixel;
            r1_d1_reg   <= r1;
            r1_d2_reg   <= r1_d1_reg;
            r2_d1_reg   <= r2;
        end
    end

    // Output register: load a new window, otherwise drop valid once accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pixel <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= frame_end;
            out_pixel <= window_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule
